// File: rtl/i2c_txn_scheduler_if.sv
// rtl/i2c_txn_scheduler_if.sv - requester and I2C master signal bundle for the transaction scheduler
interface i2c_txn_scheduler_if;
    logic [1:0] req_valid;
    logic [1:0] req_rw;
    logic [1:0] req_slave;
    logic [1:0] req_ready;
    logic [1:0] done;
    logic [1:0] err;
    logic [7:0] rsp_rdata;
    logic       busy;
    logic       m_start;
    logic       m_rw;
    logic       m_slave_sel;
    logic       m_txn_done;
    logic [7:0] m_rdata;

    modport slave (
        input  req_valid, req_rw, req_slave, m_txn_done, m_rdata,
        output req_ready, done, err, rsp_rdata, busy, m_start, m_rw, m_slave_sel
    );

    modport master (
        output req_valid, req_rw, req_slave, m_txn_done, m_rdata,
        input  req_ready, done, err, rsp_rdata, busy, m_start, m_rw, m_slave_sel
    );
endinterface

// File: rtl/i2c_txn_scheduler.sv
// rtl/i2c_txn_scheduler.sv - two-requester round-robin transaction scheduler in front of the I2C master
module i2c_txn_scheduler #(
    parameter int TIMEOUT_CYCLES = 200000,
    parameter int GAP_CYCLES     = 16,
    parameter int CW             = 18
) (
    input logic                ref_clk,
    input logic                reset,
    i2c_txn_scheduler_if.slave bus
);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST     = CW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP} state_t;

    state_t        state, state_nx;
    logic          grant, grant_nx;
    logic          ptr, ptr_nx;
    logic          rw, rw_nx;
    logic          sel, sel_nx;
    logic          txn_done_q;
    logic [CW-1:0] cnt, cnt_nx;
    logic [1:0]    done_q, done_nx;
    logic [1:0]    err_q, err_nx;
    logic [7:0]    rdata_q, rdata_nx;
    logic          edge_seen;
    logic          pick;

    // Only a fresh 0->1 transition counts; a level left high by a previous transfer is ignored.
    assign edge_seen = bus.m_txn_done & ~txn_done_q;
    assign pick      = (bus.req_valid == 2'b11) ? ptr : bus.req_valid[1];

    always_ff @(posedge ref_clk) begin
        if (reset) begin
            state      <= IDLE;
            grant      <= 1'b0;
            ptr        <= 1'b0;
            rw         <= 1'b0;
            sel        <= 1'b0;
            txn_done_q <= 1'b0;
            cnt        <= '0;
            done_q     <= '0;
            err_q      <= '0;
            rdata_q    <= '0;
        end else begin
            state      <= state_nx;
            grant      <= grant_nx;
            ptr        <= ptr_nx;
            rw         <= rw_nx;
            sel        <= sel_nx;
            txn_done_q <= bus.m_txn_done;
            cnt        <= cnt_nx;
            done_q     <= done_nx;
            err_q      <= err_nx;
            rdata_q    <= rdata_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        grant_nx      = grant;
        ptr_nx        = ptr;
        rw_nx         = rw;
        sel_nx        = sel;
        cnt_nx        = cnt;
        done_nx       = '0;
        err_nx        = '0;
        rdata_nx      = rdata_q;
        bus.req_ready = '0;
        bus.m_start   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req_valid != 2'b00 && !reset) begin
                    bus.req_ready[pick] = 1'b1;
                    grant_nx            = pick;
                    rw_nx               = bus.req_rw[pick];
                    sel_nx              = bus.req_slave[pick];
                    ptr_nx              = ~pick;
                    state_nx            = ISSUE;
                end
            end
            ISSUE: begin
                bus.m_start = 1'b1;
                cnt_nx      = '0;
                state_nx    = WAIT;
            end
            WAIT: begin
                cnt_nx = cnt + 1'b1;
                // Edge beats timeout when both land in the same cycle.
                if (edge_seen) begin
                    if (rw) rdata_nx = bus.m_rdata;
                    done_nx[grant] = 1'b1;
                    cnt_nx         = '0;
                    state_nx       = GAP;
                end else if (cnt == TIMEOUT_LAST) begin
                    done_nx[grant] = 1'b1;
                    err_nx[grant]  = 1'b1;
                    cnt_nx         = '0;
                    state_nx       = GAP;
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_nx   = '0;
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.done        = done_q;
    assign bus.err         = err_q;
    assign bus.rsp_rdata   = rdata_q;
    assign bus.m_rw        = rw;
    assign bus.m_slave_sel = sel;
    assign bus.busy        = (state != IDLE);
endmodule
